// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM arbiter.
//   arb_state_t : FSM encoding (IDLE, BUSY, RELEASE)
//   PORT_DATA   : index of requester port 0 (CPU data bus)
//   PORT_INST   : index of requester port 1 (instruction fetch / DMA)
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int PORT_DATA = 0;
    localparam int PORT_INST = 1;

endpackage

// File: rtl/sdram_arb_pick.sv
// Grant decision for the SDRAM arbiter. Pure combinational logic.
// Build option: SDRAM_ARB_RR_EN selects round-robin; otherwise fixed priority
// to port 0 with a starvation counter that hands one grant to port 1.
// Ports:
//   req        : per-port request (readEn | writeEn), bit 0 = port 0
//   last_inst  : (round-robin) 1 when port 1 held the previous grant
//   starve_cnt : (fixed priority) consecutive port-0 grants while port 1 waited
//   winner     : one-hot winner, 0 when nothing is requested
module sdram_arb_pick
    import sdram_arb_pkg::*;
`ifdef SDRAM_ARB_RR_EN
(
    input  logic [1:0]       req,
    input  logic             last_inst,
    output logic [1:0]       winner
);
`else
#(
    parameter int CNT_W        = 4,
    parameter int STARVE_LIMIT = 8
)(
    input  logic [1:0]       req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic [1:0]       winner
);
`endif

    always_comb begin
        // NOTE: default first so every path assigns winner and no latch is inferred.
        winner = 2'b00;
        if (req[PORT_DATA] && req[PORT_INST]) begin
`ifdef SDRAM_ARB_RR_EN
            // The port that did not win last time goes first.
            winner = last_inst ? 2'b01 : 2'b10;
`else
            winner = (starve_cnt == CNT_W'(STARVE_LIMIT)) ? 2'b10 : 2'b01;
`endif
        end else if (req[PORT_DATA]) begin
            winner = 2'b01;
        end else if (req[PORT_INST]) begin
            winner = 2'b10;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter sharing one Avalon-style SDRAM controller port between the
// CPU data bus (port 0) and instruction fetch / DMA (port 1). Whole
// transactions are serialised: IDLE -> BUSY (until m_waitRequest=0) ->
// RELEASE (one cycle with no command) -> IDLE.
// Build option: SDRAM_ARB_RR_EN selects round-robin arbitration; the default
// build is fixed priority to port 0 with a starvation limit for port 1.
// Ports:
//   clk, rest          : clock, asynchronous active-high reset
//   sN_*               : requester N bus (address, writeEn, writeData, readEn,
//                        byteEnable in; readData, waitRequest out)
//   m_*                : controller bus (command out, readData/waitRequest in)
//   arb_grant          : one-hot current owner, 0 when unowned
//   arb_busy           : high in BUSY or RELEASE
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W       = 23,
    parameter int DATA_W       = 32,
    parameter int BE_W         = 4,
    parameter int STARVE_LIMIT = 8
)(
    input  logic              clk,
    input  logic              rest,
    input  logic [ADDR_W-1:0] s0_address,
    input  logic              s0_writeEn,
    input  logic [DATA_W-1:0] s0_writeData,
    input  logic              s0_readEn,
    input  logic [BE_W-1:0]   s0_byteEnable,
    output logic [DATA_W-1:0] s0_readData,
    output logic              s0_waitRequest,
    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_writeEn,
    input  logic [DATA_W-1:0] s1_writeData,
    input  logic              s1_readEn,
    input  logic [BE_W-1:0]   s1_byteEnable,
    output logic [DATA_W-1:0] s1_readData,
    output logic              s1_waitRequest,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_writeEn,
    output logic [DATA_W-1:0] m_writeData,
    output logic              m_readEn,
    output logic [BE_W-1:0]   m_byteEnable,
    input  logic [DATA_W-1:0] m_readData,
    input  logic              m_waitRequest,
    output logic [1:0]        arb_grant,
    output logic              arb_busy
);

    arb_state_t state;
    logic [1:0] grant;
    logic [1:0] req;
    logic [1:0] winner;
    logic       done;

`ifdef SDRAM_ARB_RR_EN
    logic last_inst;

    sdram_arb_pick u_pick (
        .req       (req),
        .last_inst (last_inst),
        .winner    (winner)
    );
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    sdram_arb_pick #(
        .CNT_W        (CNT_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .req        (req),
        .starve_cnt (starve_cnt),
        .winner     (winner)
    );
`endif

    assign req[PORT_DATA] = s0_readEn | s0_writeEn;
    assign req[PORT_INST] = s1_readEn | s1_writeEn;

    // grant is only non-zero in BUSY; clearing it at completion leaves the
    // controller bus all-zero during RELEASE and after reset.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state      <= IDLE;
            grant      <= 2'b00;
`ifdef SDRAM_ARB_RR_EN
            last_inst  <= 1'b1;
`else
            starve_cnt <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= winner;
                        state <= BUSY;
`ifdef SDRAM_ARB_RR_EN
                        last_inst <= winner[PORT_INST];
`else
                        if (winner[PORT_DATA] && req[PORT_INST])
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        else
                            starve_cnt <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (!m_waitRequest) begin
                        grant <= 2'b00;
                        state <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Controller bus: mux of held requester inputs, selected by registered grant.
    // A combined read+write request is forwarded as a write only.
    always_comb begin
        m_address    = '0;
        m_writeEn    = 1'b0;
        m_writeData  = '0;
        m_readEn     = 1'b0;
        m_byteEnable = '0;
        case (grant)
            2'b01: begin
                m_address    = s0_address;
                m_writeEn    = s0_writeEn;
                m_writeData  = s0_writeData;
                m_readEn     = s0_readEn & ~s0_writeEn;
                m_byteEnable = s0_byteEnable;
            end
            2'b10: begin
                m_address    = s1_address;
                m_writeEn    = s1_writeEn;
                m_writeData  = s1_writeData;
                m_readEn     = s1_readEn & ~s1_writeEn;
                m_byteEnable = s1_byteEnable;
            end
            default: ;
        endcase
    end

    assign done           = (state == BUSY) && !m_waitRequest;
    assign s0_waitRequest = ~(done & grant[PORT_DATA]);
    assign s1_waitRequest = ~(done & grant[PORT_INST]);
    assign s0_readData    = (done && grant[PORT_DATA]) ? m_readData : '0;
    assign s1_readData    = (done && grant[PORT_INST]) ? m_readData : '0;
    assign arb_grant      = grant;
    assign arb_busy       = (state != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized self-checking bench for sdram_arbiter. Two requester models issue
// random read / write / read+write transactions; a controller model answers
// with random latency. A transaction-level reference model predicts owner,
// busy, the forwarded command, completion strobes and read data.
`timescale 1ns/1ps
module tb_sdram_arbiter;

    localparam int ADDR_W       = 23;
    localparam int DATA_W       = 32;
    localparam int BE_W         = 4;
    localparam int STARVE_LIMIT = 8;

    logic              clk = 1'b0;
    logic              rest;
    logic [ADDR_W-1:0] s0_address, s1_address, m_address;
    logic              s0_writeEn, s1_writeEn, m_writeEn;
    logic [DATA_W-1:0] s0_writeData, s1_writeData, m_writeData;
    logic              s0_readEn, s1_readEn, m_readEn;
    logic [BE_W-1:0]   s0_byteEnable, s1_byteEnable, m_byteEnable;
    logic [DATA_W-1:0] s0_readData, s1_readData, m_readData;
    logic              s0_waitRequest, s1_waitRequest, m_waitRequest;
    logic [1:0]        arb_grant;
    logic              arb_busy;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rest(rest),
        .s0_address(s0_address), .s0_writeEn(s0_writeEn), .s0_writeData(s0_writeData),
        .s0_readEn(s0_readEn), .s0_byteEnable(s0_byteEnable),
        .s0_readData(s0_readData), .s0_waitRequest(s0_waitRequest),
        .s1_address(s1_address), .s1_writeEn(s1_writeEn), .s1_writeData(s1_writeData),
        .s1_readEn(s1_readEn), .s1_byteEnable(s1_byteEnable),
        .s1_readData(s1_readData), .s1_waitRequest(s1_waitRequest),
        .m_address(m_address), .m_writeEn(m_writeEn), .m_writeData(m_writeData),
        .m_readEn(m_readEn), .m_byteEnable(m_byteEnable),
        .m_readData(m_readData), .m_waitRequest(m_waitRequest),
        .arb_grant(arb_grant), .arb_busy(arb_busy)
    );

    typedef struct {
        bit                act;
        bit                re;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } txn_t;

    int tests = 0;
    int fails = 0;

    // Reference model state
    txn_t        tx[2];
    int          delay[2];
    int          max_delay;
    int          owner;
    bit          rel;
    int          starve;
    bit          last_inst;
    bit          snap_req[2];
    bit          snap_done;
    int          snap_owner;
    logic [31:0] ref_mem[8];
    logic [31:0] ctl_mem[8];
    int          ctl_wait;
    int          waited[2];
    int          max_wait;
    int          completions;
    int          starve_wins;
    int          grants[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Transaction-level arbitration: applied once per clock edge.
    task automatic model_edge();
        int w;
        if (owner >= 0) begin
            if (snap_done) begin owner = -1; rel = 1'b1; end
        end else if (rel) begin
            rel = 1'b0;
        end else if (snap_req[0] || snap_req[1]) begin
            if (snap_req[0] && snap_req[1]) begin
`ifdef SDRAM_ARB_RR_EN
                w = last_inst ? 0 : 1;
`else
                w = (starve == STARVE_LIMIT) ? 1 : 0;
                if (w == 1) starve_wins++;
`endif
            end else begin
                w = snap_req[0] ? 0 : 1;
            end
`ifdef SDRAM_ARB_RR_EN
            last_inst = (w == 1);
`else
            if (w == 0 && snap_req[1]) starve++;
            else starve = 0;
`endif
            owner = w;
            grants[w]++;
        end
    endtask

    task automatic update_requesters();
        for (int p = 0; p < 2; p++) begin
            if (tx[p].act && snap_done && snap_owner == p) begin
                tx[p].act = 1'b0;
                delay[p]  = $urandom_range(0, max_delay);
            end
            if (!tx[p].act) begin
                if (delay[p] == 0) begin
                    int kind = $urandom_range(0, 2);
                    tx[p].act   = 1'b1;
                    tx[p].re    = (kind != 1);
                    tx[p].we    = (kind != 0);
                    tx[p].addr  = ADDR_W'($urandom_range(0, 7));
                    tx[p].wdata = $urandom;
                    tx[p].be    = BE_W'($urandom_range(1, 15));
                end else begin
                    delay[p]--;
                end
            end
        end
    endtask

    task automatic drive_ports();
        s0_address    = tx[0].addr;  s0_writeData = tx[0].wdata; s0_byteEnable = tx[0].be;
        s0_readEn     = tx[0].act & tx[0].re;
        s0_writeEn    = tx[0].act & tx[0].we;
        s1_address    = tx[1].addr;  s1_writeData = tx[1].wdata; s1_byteEnable = tx[1].be;
        s1_readEn     = tx[1].act & tx[1].re;
        s1_writeEn    = tx[1].act & tx[1].we;
    endtask

    // Controller model: answers the forwarded command after ctl_wait cycles.
    task automatic controller();
        m_readData = $urandom;
        if (m_readEn || m_writeEn) begin
            if (ctl_wait == 0) begin
                m_waitRequest = 1'b0;
                if (m_readEn) m_readData = ctl_mem[m_address[2:0]];
                else ctl_mem[m_address[2:0]] = merge(ctl_mem[m_address[2:0]], m_writeData, m_byteEnable);
                ctl_wait = $urandom_range(0, 3);
            end else begin
                m_waitRequest = 1'b1;
                ctl_wait--;
            end
        end else begin
            m_waitRequest = 1'b1;
        end
    endtask

    task automatic check_cycle();
        logic [63:0] exp_m = '0;
        logic [1:0]  exp_g;
        bit          done;
        exp_g = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        check("arb_grant", 64'(arb_grant), 64'(exp_g));
        check("arb_busy", 64'(arb_busy), 64'((owner >= 0) || rel));
        if (owner >= 0)
            exp_m = 64'({tx[owner].addr, tx[owner].we, tx[owner].re & ~tx[owner].we,
                         tx[owner].wdata, tx[owner].be});
        check("m_bus", 64'({m_address, m_writeEn, m_readEn, m_writeData, m_byteEnable}), exp_m);
        done = (owner >= 0) && !m_waitRequest;
        for (int p = 0; p < 2; p++) begin
            bit          mine = done && (owner == p);
            logic [31:0] exp_rd = '0;
            if (mine) exp_rd = (tx[p].re && !tx[p].we) ? ref_mem[tx[p].addr[2:0]] : m_readData;
            check($sformatf("s%0d_wait", p), 64'(p == 0 ? s0_waitRequest : s1_waitRequest), 64'(!mine));
            check($sformatf("s%0d_rdata", p), 64'(p == 0 ? s0_readData : s1_readData), 64'(exp_rd));
            if (tx[p].act && !mine) waited[p]++;
            else waited[p] = 0;
            if (waited[p] > max_wait) max_wait = waited[p];
        end
        if (done) begin
            completions++;
            if (tx[owner].we)
                ref_mem[tx[owner].addr[2:0]] = merge(ref_mem[tx[owner].addr[2:0]],
                                                     tx[owner].wdata, tx[owner].be);
        end
        snap_req[0] = tx[0].act;
        snap_req[1] = tx[1].act;
        snap_done   = done;
        snap_owner  = owner;
    endtask

    task automatic run_cycle();
        @(posedge clk); #1;
        model_edge();
        update_requesters();
        drive_ports();
        #1;
        controller();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic reset_model();
        owner     = -1;
        rel       = 1'b0;
        starve    = 0;
        last_inst = 1'b1;
        snap_done = 1'b0;
        ctl_wait  = $urandom_range(0, 3);
        m_waitRequest = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, 64'(arb_grant), 64'd0);
        check({tag, "_busy"}, 64'(arb_busy), 64'd0);
        check({tag, "_m_bus"}, 64'({m_address, m_writeEn, m_readEn, m_writeData, m_byteEnable}), 64'd0);
        check({tag, "_wait"}, 64'({s0_waitRequest, s1_waitRequest}), 64'b11);
        check({tag, "_rdata"}, 64'({s0_readData, s1_readData}), 64'd0);
    endtask

    // Reset while a transaction is in flight (not in its completion cycle).
    task automatic mid_reset();
        int n = 0;
        while (!(owner >= 0 && !snap_done) && n < 200) begin
            run_cycle();
            n++;
        end
        check("rst_pre_busy", 64'(arb_busy), 64'd1);
        #2 rest = 1'b1;
        #1 check_reset_outputs("rst_mid");
        m_waitRequest = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rest = 1'b0;
        reset_model();
    endtask

    initial begin
        rest = 1'b1;
        for (int p = 0; p < 2; p++) begin
            tx[p] = '{act: 1'b0, re: 1'b0, we: 1'b0, addr: '0, wdata: '0, be: '0};
            delay[p] = 0; waited[p] = 0; grants[p] = 0; snap_req[p] = 1'b0;
        end
        for (int a = 0; a < 8; a++) begin ref_mem[a] = '0; ctl_mem[a] = '0; end
        max_wait = 0; completions = 0; starve_wins = 0; snap_owner = -1;
        drive_ports();
        m_readData = '0;
        reset_model();
        @(posedge clk); @(posedge clk); #1;
        check_reset_outputs("rst_init");
        @(negedge clk);
        rest = 1'b0;

        max_delay = 4;
        repeat (1500) run_cycle();
        mid_reset();
        max_delay = 0;            // both ports request back-to-back
        repeat (600) run_cycle();
        mid_reset();
        max_delay = 2;
        repeat (300) run_cycle();

        check("completions_seen", 64'(completions > 100), 64'd1);
        check("port1_granted", 64'(grants[1] > 10), 64'd1);
        check("max_wait_bound", 64'(max_wait < 100), 64'd1);
`ifndef SDRAM_ARB_RR_EN
        check("starve_grants", 64'(starve_wins > 0), 64'd1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter that shares the single Avalon-style port of the SDRAM controller between two requesters: port 0 (CPU data bus) and port 1 (instruction fetch / DMA). It sits between the bus masters and the SDRAM controller. It serialises whole transactions, holds the winning request stable until the controller signals completion, and routes read data and completion back to the winner only.

## Interface
- `ADDR_W`, default 23: word address width, matching the SDRAM controller.
- `DATA_W`, default 32: data width.
- `BE_W`, default 4: byte-enable width, equal to `DATA_W/8`.
- `STARVE_LIMIT`, default 8: consecutive port-0 grants allowed while port 1 is waiting (fixed-priority mode only). Must be ≥1.

Ports (clock and reset first):
- `clk` input 1: single clock.
- `rest` input 1: reset, asynchronous, active-high.
- `sN_address` input `ADDR_W`, N=0,1: requester word address.
- `sN_writeEn` input 1: write request, held until completion.
- `sN_writeData` input `DATA_W`: write data.
- `sN_readEn` input 1: read request, held until completion.
- `sN_byteEnable` input `BE_W`: write byte enables.
- `sN_readData` output `DATA_W`: read data, valid only in the completion cycle.
- `sN_waitRequest` output 1: 1 = stall; a single-cycle 0 marks completion.
- `m_address`, `m_writeEn`, `m_writeData`, `m_readEn`, `m_byteEnable` output: to the SDRAM controller.
- `m_readData` input `DATA_W`: from the SDRAM controller.
- `m_waitRequest` input 1: the controller's busy/quest flag; a 0 seen in BUSY marks completion.
- `arb_grant` output 2: one-hot current owner; 0 when no port owns the controller.
- `arb_busy` output 1: 1 in BUSY or RELEASE.

## Operation
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - A request is `readEn|writeEn` on a port.
  - If any port requests, latch the winner into `grant` and go to BUSY.
  - If no port requests, stay in IDLE.
- BUSY:
  - `m_*` outputs are driven from the granted port's inputs through a mux selected by the registered `grant`.
  - If the granted port sets both `readEn` and `writeEn`, the arbiter forwards a write only (`m_readEn`=0).
  - When `m_waitRequest`=0, the cycle is a completion:
    - the granted port's `sN_waitRequest`=0;
    - `sN_readData`=`m_readData`;
    - next state is RELEASE.
- RELEASE: one cycle with `m_readEn`=`m_writeEn`=0 so the controller returns to idle; next state is IDLE.
- The non-granted port always sees `sN_waitRequest`=1 and `sN_readData`=0.
- Arbitration in fixed-priority mode (default):
  - Port 0 wins.
  - `starve_cnt` counts consecutive port-0 grants made while port 1 was requesting.
  - When `starve_cnt`=`STARVE_LIMIT`, port 1 wins and the counter clears.
  - Any port-1 grant, or any port-0 grant made while port 1 is idle, also clears the counter.
- Reset values:
  - state=IDLE, `grant`=0, `starve_cnt`=0;
  - all `m_*` outputs=0;
  - `sN_waitRequest`=1, `sN_readData`=0;
  - `arb_grant`=0, `arb_busy`=0.
- Reset mid-transaction: return immediately to IDLE; no completion pulse is issued. The requester must re-issue.
- A requester that drops its request while in BUSY is illegal. The arbiter keeps forwarding the live inputs and does not guard against it.

## Timing
- Request first seen in IDLE at cycle t:
  - `grant` and `m_*` are valid at t+1;
  - the earliest completion is the first cycle from t+1 with `m_waitRequest`=0.
- Completion at cycle c: RELEASE at c+1, IDLE at c+2, the next grant at c+3 at the earliest.
- Minimum arbiter overhead is 3 cycles per transaction, in addition to the controller latency.
- `m_*` outputs change only on a grant change. They are a combinational mux of the registered `grant` and the held inputs, with no path from `m_waitRequest` to `m_*`.
- Simultaneous requests in IDLE are resolved in the same cycle; exactly one port is granted.

## Configuration
- `SDRAM_ARB_RR_EN` defined:
  - Round-robin: on simultaneous requests, the port not granted last wins.
  - The last-grant register resets to port 1, so port 0 wins first.
  - `STARVE_LIMIT` and `starve_cnt` are not compiled.
- `SDRAM_ARB_RR_EN` undefined: fixed priority with the starvation counter, as described in Operation.

## Structure
- A shared package `sdram_arb_pkg` holds:
  - the state encoding constants (IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2);
  - the port index constants (PORT_DATA=0, PORT_INST=1).
- One sub-module, `sdram_arb_pick`: the pure grant-decision logic. It takes requests plus last grant or `starve_cnt` and returns a one-hot winner. It is shared by both configurations through the macro.
- The top level contains the FSM, the counter and the muxes.

## Test plan
- Port 0 read only, address 23'h000100:
  - `m_readEn`=1 one cycle after the request.
  - When the model returns 32'hDEADBEEF with `m_waitRequest`=0, `s0_readData`=32'hDEADBEEF and `s0_waitRequest`=0 for exactly 1 cycle.
  - `m_readEn`=0 in the following cycle.
- Both ports request a write in the same cycle (default build): port 0 is granted first and port 1 is granted at completion+3. `m_writeData` and `m_byteEnable` match each port's values in turn.
- Port 0 requests continuously while port 1 waits, `STARVE_LIMIT`=8: the ninth grant goes to port 1.
- `SDRAM_ARB_RR_EN` build, both ports requesting continuously: grants alternate 0,1,0,1.
- Port 1 sets `readEn`=`writeEn`=1: only `m_writeEn`=1 is forwarded.
- Assert `rest` while in BUSY: within the same cycle all `m_*` outputs=0, `sN_waitRequest`=1, `arb_grant`=0. After release, a new request is granted normally.
